// File: rtl/mi32_arb_pkg.sv
// Shared types, MI32 field widths and the round-robin helper used by the
// MI32 arbiter family.
package mi32_arb_pkg;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int BE_W        = 4;
  localparam int MAX_MASTERS = 8;
  localparam int IDX_W       = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_e;

  // First requester after 'last', wrapping modulo n; returns 'last' when idle.
  function automatic logic [IDX_W-1:0] rr_next(input logic [MAX_MASTERS-1:0] req,
                                               input logic [IDX_W-1:0]       last,
                                               input int                     n);
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;
    logic             found;
    int               idx;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= MAX_MASTERS; k++) begin
      idx  = (int'(last) + k) % n;
      cand = idx[IDX_W-1:0];
      if ((k <= n) && !found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/mi32_rr_select.sv
// Combinational round-robin priority select: picks the next requester after
// the previous winner. Shared by any arbiter built on mi32_arb_pkg.
module mi32_rr_select
  import mi32_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  logic [MAX_MASTERS-1:0] req_pad_s;

  assign req_pad_s = MAX_MASTERS'(req);

  // Winner index and any-request flag
  always_comb begin
    winner  = rr_next(req_pad_s, last, N);
    any_req = |req;
  end

endmodule

// File: rtl/mi32_arbiter.sv
// Round-robin arbiter sharing one MI32 slave between NUM_MASTERS masters,
// one transaction in flight, with a read-data timeout.
module mi32_arbiter
  import mi32_arb_pkg::*;
#(
  parameter int                NUM_MASTERS  = 2,
  parameter int                TIMEOUT      = 256,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEADDEAD
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [DATA_W*NUM_MASTERS-1:0] M_DWR,
  input  logic [ADDR_W*NUM_MASTERS-1:0] M_ADDR,
  input  logic [BE_W*NUM_MASTERS-1:0]   M_BE,
  input  logic [NUM_MASTERS-1:0]        M_RD,
  input  logic [NUM_MASTERS-1:0]        M_WR,
  output logic [NUM_MASTERS-1:0]        M_ARDY,
  output logic [DATA_W-1:0]             M_DRD,
  output logic [NUM_MASTERS-1:0]        M_DRDY,
  output logic [DATA_W-1:0]             S_DWR,
  output logic [ADDR_W-1:0]             S_ADDR,
  output logic [BE_W-1:0]               S_BE,
  output logic                          S_RD,
  output logic                          S_WR,
  input  logic                          S_ARDY,
  input  logic [DATA_W-1:0]             S_DRD,
  input  logic                          S_DRDY,
  output logic                          TIMEOUT_ERR
);

  localparam int                CNT_W     = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0]  LAST_INIT = IDX_W'(NUM_MASTERS - 1);

  arb_state_e             state_r, state_n_s;
  logic [IDX_W-1:0]       grant_r, grant_n_s;
  logic [IDX_W-1:0]       last_r, last_n_s;
  logic [CNT_W-1:0]       cnt_r, cnt_n_s;

  logic [NUM_MASTERS-1:0] req_s;
  logic [IDX_W-1:0]       winner_s;
  logic                   any_req_s;
  logic [MAX_MASTERS-1:0] rd_pad_s, wr_pad_s;
  logic [MAX_MASTERS-1:0] ardy_pad_s, drdy_pad_s;
  logic                   g_wr_s, g_rd_s;

  logic [DATA_W-1:0]      dwr_a_s  [MAX_MASTERS];
  logic [ADDR_W-1:0]      addr_a_s [MAX_MASTERS];
  logic [BE_W-1:0]        be_a_s   [MAX_MASTERS];

  // Per-master fields padded to MAX_MASTERS so the grant index is always in range.
  for (genvar i = 0; i < MAX_MASTERS; i++) begin : g_unpack
    if (i < NUM_MASTERS) begin : g_used
      assign dwr_a_s[i]  = M_DWR[DATA_W*i +: DATA_W];
      assign addr_a_s[i] = M_ADDR[ADDR_W*i +: ADDR_W];
      assign be_a_s[i]   = M_BE[BE_W*i +: BE_W];
    end else begin : g_unused
      assign dwr_a_s[i]  = {DATA_W{1'b0}};
      assign addr_a_s[i] = {ADDR_W{1'b0}};
      assign be_a_s[i]   = {BE_W{1'b0}};
    end
  end

  assign req_s    = M_RD | M_WR;
  assign rd_pad_s = MAX_MASTERS'(M_RD);
  assign wr_pad_s = MAX_MASTERS'(M_WR);
  // Write wins over an illegal simultaneous read on the same master.
  assign g_wr_s   = wr_pad_s[grant_r];
  assign g_rd_s   = rd_pad_s[grant_r] & ~g_wr_s;
  assign M_ARDY   = ardy_pad_s[NUM_MASTERS-1:0];
  assign M_DRDY   = drdy_pad_s[NUM_MASTERS-1:0];

  mi32_rr_select #(
    .N (NUM_MASTERS)
  ) u_rr_select (
    .req     (req_s),
    .last    (last_r),
    .winner  (winner_s),
    .any_req (any_req_s)
  );

  // State, grant, round-robin pointer and read timeout counter
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r <= IDLE;
      grant_r <= {IDX_W{1'b0}};
      last_r  <= LAST_INIT;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_n_s;
      grant_r <= grant_n_s;
      last_r  <= last_n_s;
      cnt_r   <= cnt_n_s;
    end
  end

  // Next-state logic and slave/master muxing
  always_comb begin
    state_n_s   = state_r;
    grant_n_s   = grant_r;
    last_n_s    = last_r;
    cnt_n_s     = cnt_r;
    ardy_pad_s  = {MAX_MASTERS{1'b0}};
    drdy_pad_s  = {MAX_MASTERS{1'b0}};
    M_DRD       = {DATA_W{1'b0}};
    S_DWR       = {DATA_W{1'b0}};
    S_ADDR      = {ADDR_W{1'b0}};
    S_BE        = {BE_W{1'b0}};
    S_RD        = 1'b0;
    S_WR        = 1'b0;
    TIMEOUT_ERR = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          grant_n_s = winner_s;
          last_n_s  = winner_s;
          state_n_s = BUSY;
        end else begin
          state_n_s = IDLE;
        end
      end
      BUSY: begin
        S_DWR  = dwr_a_s[grant_r];
        S_ADDR = addr_a_s[grant_r];
        S_BE   = be_a_s[grant_r];
        S_WR   = g_wr_s;
        S_RD   = g_rd_s;
        // An abandoned request must not see an accept pulse.
        ardy_pad_s[grant_r] = S_ARDY & (g_wr_s | g_rd_s);
        if (!(g_wr_s | g_rd_s)) begin
          state_n_s = IDLE;
        end else if (!S_ARDY) begin
          state_n_s = BUSY;
        end else if (g_wr_s) begin
          state_n_s = IDLE;
        end else if (S_DRDY) begin
          drdy_pad_s[grant_r] = 1'b1;
          M_DRD               = S_DRD;
          state_n_s           = IDLE;
        end else begin
          cnt_n_s   = {CNT_W{1'b0}};
          state_n_s = WAIT_RD;
        end
      end
      WAIT_RD: begin
        M_DRD = S_DRD;
        if (S_DRDY) begin
          drdy_pad_s[grant_r] = 1'b1;
          state_n_s           = IDLE;
        end else if (cnt_r == CNT_LAST) begin
          drdy_pad_s[grant_r] = 1'b1;
          M_DRD               = TIMEOUT_DATA;
          TIMEOUT_ERR         = 1'b1;
          state_n_s           = IDLE;
        end else if (cnt_r != CNT_MAX) begin
          cnt_n_s = cnt_r + CNT_ONE;
        end else begin
          cnt_n_s = cnt_r;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mi32_arbiter.sv
// Self-checking bench for mi32_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked against a transaction-level model.
module tb_mi32_arbiter;

  localparam int NM = 3;
  localparam int TO = 8;
  localparam logic [31:0] TD = 32'hDEADDEAD;

  logic            CLK = 1'b0;
  logic            RESET;
  logic [32*NM-1:0] M_DWR, M_ADDR;
  logic [4*NM-1:0] M_BE;
  logic [NM-1:0]   M_RD, M_WR, M_ARDY, M_DRDY;
  logic [31:0]     M_DRD, S_DWR, S_ADDR, S_DRD;
  logic [3:0]      S_BE;
  logic            S_RD, S_WR, S_ARDY, S_DRDY, TIMEOUT_ERR;

  int n_cmp = 0;
  int n_bad = 0;

  mi32_arbiter #(
    .NUM_MASTERS (NM),
    .TIMEOUT     (TO),
    .TIMEOUT_DATA(TD)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .M_DWR(M_DWR), .M_ADDR(M_ADDR), .M_BE(M_BE), .M_RD(M_RD), .M_WR(M_WR),
    .M_ARDY(M_ARDY), .M_DRD(M_DRD), .M_DRDY(M_DRDY),
    .S_DWR(S_DWR), .S_ADDR(S_ADDR), .S_BE(S_BE), .S_RD(S_RD), .S_WR(S_WR),
    .S_ARDY(S_ARDY), .S_DRD(S_DRD), .S_DRDY(S_DRDY), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_srd"},  32'(S_RD), 32'd0);
    check({tag, "_swr"},  32'(S_WR), 32'd0);
    check({tag, "_sadr"}, S_ADDR, 32'd0);
    check({tag, "_sdwr"}, S_DWR, 32'd0);
    check({tag, "_sbe"},  32'(S_BE), 32'd0);
    check({tag, "_ardy"}, 32'(M_ARDY), 32'd0);
    check({tag, "_drdy"}, 32'(M_DRDY), 32'd0);
    check({tag, "_mdrd"}, M_DRD, 32'd0);
    check({tag, "_err"},  32'(TIMEOUT_ERR), 32'd0);
  endtask

  // ---------------- transaction-level reference model ----------------
  int  owner   = -1;    // master holding the slave, -1 when free
  bit  reading = 1'b0;  // read accepted, data outstanding
  int  acc_cyc = 0;     // cycle the read was accepted
  int  last    = NM - 1;
  int  cyc     = 0;
  logic [NM-1:0] e_ardy, e_drdy;
  logic [31:0]   e_drd, e_dwr, e_addr;
  logic [3:0]    e_be;
  logic          e_rd, e_wr, e_err;
  bit            w, r;

  always @(negedge CLK) begin
    cyc++;
    e_ardy = '0; e_drdy = '0; e_drd = '0; e_dwr = '0; e_addr = '0; e_be = '0;
    e_rd = 1'b0; e_wr = 1'b0; e_err = 1'b0;
    if (!RESET) begin
      owner = -1; reading = 1'b0; last = NM - 1;
    end else if (owner < 0) begin
      for (int k = 1; k <= NM; k++) begin
        if (owner < 0 && (M_RD[(last + k) % NM] || M_WR[(last + k) % NM])) begin
          owner = (last + k) % NM;
        end
      end
      if (owner >= 0) last = owner;
      reading = 1'b0;
    end else if (!reading) begin
      w = M_WR[owner];
      r = M_RD[owner] && !w;
      e_wr = w; e_rd = r;
      e_addr = M_ADDR[32*owner +: 32];
      e_dwr  = M_DWR[32*owner +: 32];
      e_be   = M_BE[4*owner +: 4];
      if (w || r) e_ardy[owner] = S_ARDY;
      if (!(w || r)) owner = -1;
      else if (S_ARDY && w) owner = -1;
      else if (S_ARDY && S_DRDY) begin
        e_drdy[owner] = 1'b1; e_drd = S_DRD; owner = -1;
      end else if (S_ARDY) begin
        reading = 1'b1; acc_cyc = cyc;
      end
    end else begin
      e_drd = S_DRD;
      if (S_DRDY) begin
        e_drdy[owner] = 1'b1; owner = -1; reading = 1'b0;
      end else if (cyc - acc_cyc == TO) begin
        e_drdy[owner] = 1'b1; e_drd = TD; e_err = 1'b1; owner = -1; reading = 1'b0;
      end
    end
    check("m_srd",  32'(S_RD), 32'(e_rd));
    check("m_swr",  32'(S_WR), 32'(e_wr));
    check("m_sadr", S_ADDR, e_addr);
    check("m_sdwr", S_DWR, e_dwr);
    check("m_sbe",  32'(S_BE), 32'(e_be));
    check("m_ardy", 32'(M_ARDY), 32'(e_ardy));
    check("m_drdy", 32'(M_DRDY), 32'(e_drdy));
    check("m_drd",  M_DRD, e_drd);
    check("m_err",  32'(TIMEOUT_ERR), 32'(e_err));
  end

  // ---------------- stimulus ----------------
  task automatic drive_edge();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset(input string tag);
    @(posedge CLK); #2;
    RESET = 1'b0;
    #1 check_quiet(tag);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
  endtask

  int            grants [6];
  int            ng;
  int            n;
  logic [NM-1:0] got;
  int            op;

  initial begin
    RESET = 1'b0; M_DWR = '0; M_ADDR = '0; M_BE = '0; M_RD = '0; M_WR = '0;
    S_ARDY = 1'b0; S_DRD = '0; S_DRDY = 1'b0;
    repeat (3) @(negedge CLK);
    check_quiet("rst");
    drive_edge(); RESET = 1'b1;

    // single write, then a second back-to-back write: 2 cycles each
    drive_edge();
    M_WR[0] = 1'b1; M_ADDR[31:0] = 32'h10; M_DWR[31:0] = 32'hA5A5A5A5; M_BE[3:0] = 4'hF; S_ARDY = 1'b1;
    @(negedge CLK); check("wr_arb_cycle", 32'(S_WR), 32'd0);
    @(negedge CLK);
    check("wr_swr", 32'(S_WR), 32'd1);
    check("wr_addr", S_ADDR, 32'h10);
    check("wr_dwr", S_DWR, 32'hA5A5A5A5);
    check("wr_ardy", 32'(M_ARDY), 32'd1);
    @(negedge CLK); check("wr2_idle", 32'(S_WR), 32'd0);
    @(negedge CLK); check("wr2_swr", 32'(S_WR), 32'd1);
    drive_edge(); M_WR = '0; S_ARDY = 1'b0;

    // read with 3-cycle data latency on master 1
    drive_edge(); M_RD[1] = 1'b1; M_ADDR[63:32] = 32'h20; S_ARDY = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("rd_srd", 32'(S_RD), 32'd1);
    check("rd_addr", S_ADDR, 32'h20);
    check("rd_ardy", 32'(M_ARDY), 32'b010);
    drive_edge(); M_RD = '0; S_ARDY = 1'b0;
    repeat (2) begin
      @(negedge CLK); check("rd_wait_drdy", 32'(M_DRDY), 32'd0);
    end
    drive_edge(); S_DRDY = 1'b1; S_DRD = 32'h12345678;
    @(negedge CLK);
    check("rd_drdy", 32'(M_DRDY), 32'b010);
    check("rd_drd", M_DRD, 32'h12345678);
    drive_edge(); S_DRDY = 1'b0;

    // round-robin among three continuously writing masters
    do_reset("rst_rr");
    drive_edge();
    M_WR = 3'b111; S_ARDY = 1'b1;
    for (int i = 0; i < NM; i++) M_ADDR[32*i +: 32] = 32'h100 + 32'(i);
    for (int i = 0; i < 6; i++) grants[i] = -1;
    ng = 0;
    for (int k = 0; k < 20 && ng < 6; k++) begin
      @(negedge CLK);
      if (S_WR) begin
        grants[ng] = int'(S_ADDR) - 32'sh100;
        ng++;
      end
    end
    for (int i = 0; i < 6; i++) check("rr_order", 32'(grants[i]), 32'(i % NM));
    drive_edge(); M_WR = '0; S_ARDY = 1'b0;

    // read timeout, then late data is dropped
    drive_edge(); M_RD[0] = 1'b1; M_ADDR[31:0] = 32'h30; S_ARDY = 1'b1;
    @(negedge CLK);
    @(negedge CLK); check("to_accept", 32'(S_RD), 32'd1);
    drive_edge(); M_RD = '0; S_ARDY = 1'b0;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if (M_DRDY != '0 && n == 0) n = k;
      if (n != 0) break;
    end
    check("to_latency", 32'(n), 32'd8);
    check("to_drdy", 32'(M_DRDY), 32'b001);
    check("to_drd", M_DRD, 32'hDEADDEAD);
    check("to_err", 32'(TIMEOUT_ERR), 32'd1);
    drive_edge();
    drive_edge(); S_DRDY = 1'b1; S_DRD = 32'h55555555;
    @(negedge CLK);
    check("late_drdy", 32'(M_DRDY), 32'd0);
    check("late_err", 32'(TIMEOUT_ERR), 32'd0);
    drive_edge(); S_DRDY = 1'b0;

    // master 0 abandons before accept, master 1 gets the next grant
    do_reset("rst_ab");
    drive_edge();
    M_WR = 3'b011; M_ADDR[31:0] = 32'h40; M_ADDR[63:32] = 32'h41;
    @(negedge CLK);
    @(negedge CLK);
    check("ab_first", S_ADDR, 32'h40);
    check("ab_ardy0", 32'(M_ARDY), 32'd0);
    drive_edge(); M_WR[0] = 1'b0;
    @(negedge CLK); check("ab_drop_swr", 32'(S_WR), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    check("ab_next_swr", 32'(S_WR), 32'd1);
    check("ab_next_addr", S_ADDR, 32'h41);
    drive_edge(); S_ARDY = 1'b1;
    drive_edge(); M_WR = '0; S_ARDY = 1'b0;

    // reset while master 0 waits for read data
    drive_edge(); M_RD[0] = 1'b1; M_ADDR[31:0] = 32'h50; S_ARDY = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    drive_edge(); M_RD = '0; S_ARDY = 1'b0;
    @(negedge CLK);
    #2 S_DRDY = 1'b1; RESET = 1'b0;
    #1 check_quiet("rst_wait");
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1; S_DRDY = 1'b0;
    M_WR = 3'b011; M_ADDR[31:0] = 32'h60; M_ADDR[63:32] = 32'h61; S_ARDY = 1'b1;
    @(negedge CLK);
    @(negedge CLK); check("rst_winner", S_ADDR, 32'h60);
    drive_edge(); M_WR = '0; S_ARDY = 1'b0;

    // randomized traffic, checked every cycle by the model
    for (int it = 0; it < 3000; it++) begin
      @(negedge CLK); got = M_ARDY;
      drive_edge();
      RESET = (it == 1500) ? 1'b0 : 1'b1;
      for (int i = 0; i < NM; i++) begin
        if (M_RD[i] || M_WR[i]) begin
          if (got[i] || $urandom_range(0, 19) == 0) begin
            M_RD[i] = 1'b0; M_WR[i] = 1'b0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          op = $urandom_range(0, 9);
          M_RD[i] = (op < 5) || (op == 9);
          M_WR[i] = (op >= 5);
          M_ADDR[32*i +: 32] = $urandom;
          M_DWR[32*i +: 32]  = $urandom;
          M_BE[4*i +: 4]     = 4'($urandom);
        end
      end
      S_ARDY = 1'($urandom_range(0, 1));
      S_DRDY = ($urandom_range(0, 4) == 0);
      S_DRD  = $urandom;
    end
    @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
